// File: rtl/reg_cmd_ctrl.sv
// Register-file command initiator: decodes UART write/read frames into register
// strobes and returns read data as a single TX byte.
`timescale 1ns/1ps
module reg_cmd_ctrl #(
    parameter int unsigned      width      = 8,
    parameter int unsigned      ADDR_W     = 4,
    parameter logic [width-1:0] WR_CMD     = 8'hAA,
    parameter logic [width-1:0] RD_CMD     = 8'hBB,
    parameter int unsigned      RD_TIMEOUT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [width-1:0]  RX_P_DATA,
    input  logic              RX_D_VLD,
    input  logic [width-1:0]  RdData,
    input  logic              RdData_Valid,
    input  logic              TX_Busy,
    output logic              WrEn,
    output logic              RdEn,
    output logic [ADDR_W-1:0] Address,
    output logic [width-1:0]  WrData,
    output logic [width-1:0]  TX_P_DATA,
    output logic              TX_D_VLD,
    output logic              Ctrl_Busy,
    output logic              Cmd_Err,
    output logic              Rx_Overrun
);

    localparam int unsigned CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_REQ,
        S_RD_WAIT,
        S_TX_SEND
    } state_t;

    state_t            state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [width-1:0]  wr_data_q, wr_data_d;
    logic [width-1:0]  tx_data_q, tx_data_d;
    logic              tx_vld_q, tx_vld_d;
    logic              busy_q, busy_d;
    logic              cmd_err_q, cmd_err_d;
    logic              rx_ovr_q, rx_ovr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              in_busy_state;
    logic              addr_ok;

    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        tx_data_d = tx_data_q;
        tx_vld_d  = tx_vld_q;
        cmd_err_d = 1'b0;
        rx_ovr_d  = 1'b0;
        cnt_d     = cnt_q;

        in_busy_state = state_q inside {S_RD_REQ, S_RD_WAIT, S_TX_SEND};
        addr_ok       = (RX_P_DATA[width-1:ADDR_W] == '0);

        // Bytes arriving while a read is in flight are dropped, never queued.
        if (RX_D_VLD && in_busy_state) begin
            rx_ovr_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == WR_CMD) begin
                        state_d = S_WR_ADDR;
                    end else if (RX_P_DATA == RD_CMD) begin
                        state_d = S_RD_ADDR;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            S_WR_ADDR: begin
                if (RX_D_VLD) begin
                    if (!addr_ok) begin
                        cmd_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        addr_d  = RX_P_DATA[ADDR_W-1:0];
                        state_d = S_WR_DATA;
                    end
                end
            end
            S_WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_data_d = RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (RX_D_VLD) begin
                    if (!addr_ok) begin
                        cmd_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        addr_d  = RX_P_DATA[ADDR_W-1:0];
                        rd_en_d = 1'b1;
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                cnt_d   = '0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (RdData_Valid) begin
                    tx_data_d = RdData;
                    tx_vld_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_TX_SEND;
                end else if (cnt_q == CNT_LAST) begin
                    cmd_err_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_TX_SEND: begin
                if (tx_vld_q && !TX_Busy) begin
                    tx_vld_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered from the next state so Ctrl_Busy lines up with the state it describes.
        busy_d = state_d inside {S_RD_REQ, S_RD_WAIT, S_TX_SEND};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
            busy_q    <= 1'b0;
            cmd_err_q <= 1'b0;
            rx_ovr_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
            busy_q    <= busy_d;
            cmd_err_q <= cmd_err_d;
            rx_ovr_q  <= rx_ovr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign WrEn       = wr_en_q;
    assign RdEn       = rd_en_q;
    assign Address    = addr_q;
    assign WrData     = wr_data_q;
    assign TX_P_DATA  = tx_data_q;
    assign TX_D_VLD   = tx_vld_q;
    assign Ctrl_Busy  = busy_q;
    assign Cmd_Err    = cmd_err_q;
    assign Rx_Overrun = rx_ovr_q;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Bench for reg_cmd_ctrl: frame-level reference model pushes time-stamped expected
// events into a scoreboard; a monitor pops one per observed output event.
`timescale 1ns/1ps
module tb_reg_cmd_ctrl;

    localparam int RD_TIMEOUT = 4;
    localparam logic [7:0] WR = 8'hAA;
    localparam logic [7:0] RD = 8'hBB;
    localparam int K_WR = 0, K_RD = 1, K_TX = 2, K_ERR = 3, K_OVR = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] RX_P_DATA;
    logic       RX_D_VLD;
    wire  [7:0] RdData;
    wire        RdData_Valid;
    logic       TX_Busy;
    logic       WrEn, RdEn;
    logic [3:0] Address;
    logic [7:0] WrData, TX_P_DATA;
    logic       TX_D_VLD, Ctrl_Busy, Cmd_Err, Rx_Overrun;

    logic       rsp_valid, spur_valid;
    logic [7:0] rsp_data, spur_data;
    int         rsp_delay;

    assign RdData_Valid = rsp_valid | spur_valid;
    assign RdData       = rsp_valid ? rsp_data : spur_data;

    reg_cmd_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_P_DATA    (RX_P_DATA),
        .RX_D_VLD     (RX_D_VLD),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .TX_Busy      (TX_Busy),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .Address      (Address),
        .WrData       (WrData),
        .TX_P_DATA    (TX_P_DATA),
        .TX_D_VLD     (TX_D_VLD),
        .Ctrl_Busy    (Ctrl_Busy),
        .Cmd_Err      (Cmd_Err),
        .Rx_Overrun   (Rx_Overrun)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] a;
        logic [7:0] d;
    } ev_t;

    ev_t        exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] mem [16];

    // Keep the queue ordered by (cycle, kind) so the monitor can pop in order.
    function automatic void push_ev(int kind, int c, logic [7:0] a, logic [7:0] d);
        ev_t e;
        int  i;
        e.kind = kind; e.cyc = c; e.a = a; e.d = d;
        i = 0;
        while (i < exp_q.size() && (exp_q[i].cyc * 8 + exp_q[i].kind) <= (c * 8 + kind)) i++;
        exp_q.insert(i, e);
    endfunction

    task automatic check_ev(input int kind, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind=%0d cyc=%0d a=%h d=%h, required no event",
                     kind, cyc, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.a != a || e.d != d) begin
                n_err++;
                $display("FAIL event: got kind=%0d cyc=%0d a=%h d=%h, required kind=%0d cyc=%0d a=%h d=%h",
                         kind, cyc, a, d, e.kind, e.cyc, e.a, e.d);
            end
        end
    endtask

    // Monitor
    initial begin
        logic       prev_hold;
        logic [7:0] prev_data;
        prev_hold = 1'b0;
        prev_data = 8'h00;
        forever begin
            @(negedge CLK);
            if (WrEn === 1'b1)                         check_ev(K_WR, {4'h0, Address}, WrData);
            if (RdEn === 1'b1)                         check_ev(K_RD, {4'h0, Address}, 8'h00);
            if (TX_D_VLD === 1'b1 && TX_Busy === 1'b0) check_ev(K_TX, 8'h00, TX_P_DATA);
            if (Cmd_Err === 1'b1)                      check_ev(K_ERR, 8'h00, 8'h00);
            if (Rx_Overrun === 1'b1)                   check_ev(K_OVR, 8'h00, 8'h00);
            if (prev_hold && TX_D_VLD === 1'b1) begin
                n_vec++;
                if (TX_P_DATA !== prev_data) begin
                    n_err++;
                    $display("FAIL tx_hold: TX_P_DATA=%h, required %h while held", TX_P_DATA, prev_data);
                end
            end
            prev_hold = (TX_D_VLD === 1'b1) && (TX_Busy === 1'b1);
            prev_data = TX_P_DATA;
        end
    end

    // Register-file responder: answers rsp_delay cycles after the cycle following RdEn.
    initial begin
        logic [7:0] rf [16];
        logic [3:0] ra;
        int         dl;
        for (int i = 0; i < 16; i++) rf[i] = 8'h00;
        rsp_valid = 1'b0;
        rsp_data  = 8'h00;
        forever begin
            @(negedge CLK);
            if (WrEn === 1'b1 && RST === 1'b0) rf[Address] = WrData;
            if (RdEn === 1'b1 && RST === 1'b0) begin
                ra = Address;
                dl = rsp_delay;
                if (dl >= 0) begin
                    repeat (dl + 1) @(posedge CLK);
                    #1;
                    rsp_data  = rf[ra];
                    rsp_valid = 1'b1;
                    @(posedge CLK);
                    #1;
                    rsp_valid = 1'b0;
                    rsp_data  = 8'($urandom);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, output int n);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        n         = cyc;
        tick();
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'($urandom);
    endtask

    task automatic check_zero(input string nm);
        @(negedge CLK);
        n_vec++;
        if ({WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, Ctrl_Busy, Cmd_Err, Rx_Overrun} !== '0) begin
            n_err++;
            $display("FAIL %s: outputs WrEn=%b RdEn=%b Addr=%h WrData=%h TX=%h TXV=%b Busy=%b Err=%b Ovr=%b, required all 0",
                     nm, WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, Ctrl_Busy, Cmd_Err, Rx_Overrun);
        end
        tick();
    endtask

    task automatic wr_frame(input logic [7:0] ab, input logic [7:0] db);
        int n;
        send_byte(WR, n);
        gap();
        send_byte(ab, n);
        if (ab >= 16) begin
            push_ev(K_ERR, n + 1, 8'h00, 8'h00);
            return;
        end
        gap();
        send_byte(db, n);
        push_ev(K_WR, n + 1, ab, db);
        mem[ab[3:0]] = db;
    endtask

    // d: responder delay after the RdEn+1 cycle (<0 never); b: TX busy cycles; ovr: inject a byte mid-read.
    task automatic rd_frame(input logic [7:0] ab, input int d, input int b, input bit ovr);
        int n, t, last, k;
        TX_Busy   = (b > 0);
        rsp_delay = d;
        send_byte(RD, n);
        gap();
        send_byte(ab, n);
        if (ab >= 16) begin
            push_ev(K_ERR, n + 1, 8'h00, 8'h00);
            TX_Busy = 1'b0;
            return;
        end
        push_ev(K_RD, n + 1, ab, 8'h00);
        if (d >= 0 && d < RD_TIMEOUT) begin
            t    = n + 3 + d + b;
            last = t;
            push_ev(K_TX, t, 8'h00, mem[ab[3:0]]);
        end else begin
            t    = -1;
            last = n + 1 + RD_TIMEOUT;
            push_ev(K_ERR, last + 1, 8'h00, 8'h00);
        end
        k = -1;
        if (ovr) begin
            k = int'($urandom_range(last, n + 1));
            push_ev(K_OVR, k + 1, 8'h00, 8'h00);
        end
        for (int c = n + 1; c <= last + 1; c++) begin
            if (c == k) begin
                RX_P_DATA = 8'($urandom);
                RX_D_VLD  = 1'b1;
            end else begin
                RX_D_VLD  = 1'b0;
            end
            if (c == t) TX_Busy = 1'b0;
            @(negedge CLK);
            n_vec++;
            if (Ctrl_Busy !== (c <= last)) begin
                n_err++;
                $display("FAIL ctrl_busy: cyc=%0d got %b, required %b", cyc, Ctrl_Busy, (c <= last));
            end
            tick();
        end
        RX_D_VLD = 1'b0;
        TX_Busy  = 1'b0;
    endtask

    task automatic junk_byte();
        logic [7:0] b;
        int n;
        b = 8'($urandom);
        while (b == WR || b == RD) b = 8'($urandom);
        send_byte(b, n);
        push_ev(K_ERR, n + 1, 8'h00, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin
        int n;
        RST        = 1'b1;
        RX_P_DATA  = 8'h00;
        RX_D_VLD   = 1'b0;
        TX_Busy    = 1'b0;
        spur_valid = 1'b0;
        spur_data  = 8'h00;
        rsp_delay  = -1;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        repeat (3) tick();
        RST = 1'b0;
        check_zero("reset");

        wr_frame(8'h05, 8'h3C);
        rd_frame(8'h05, 0, 0, 1'b0);
        rd_frame(8'h05, 0, 5, 1'b0);
        send_byte(8'h11, n);
        push_ev(K_ERR, n + 1, 8'h00, 8'h00);
        wr_frame(8'h1F, 8'h55);
        wr_frame(8'h02, 8'h7E);
        rd_frame(8'h02, 3, 1, 1'b1);
        rd_frame(8'h03, -1, 0, 1'b0);

        // Reset while waiting for read data
        rsp_delay = -1;
        send_byte(RD, n);
        send_byte(8'h05, n);
        push_ev(K_RD, n + 1, 8'h05, 8'h00);
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_zero("rst_rd_wait");

        // Reset mid write frame; the stale frame must not resume
        send_byte(WR, n);
        send_byte(8'h05, n);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_zero("rst_wr_data");
        send_byte(8'h05, n);
        push_ev(K_ERR, n + 1, 8'h00, 8'h00);
        tick();

        for (int i = 0; i < 200; i++) begin
            int sel, r, dly;
            logic [7:0] ab;
            sel = int'($urandom_range(0, 9));
            ab  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
            if (sel < 4) begin
                wr_frame(ab, 8'($urandom));
            end else if (sel < 8) begin
                r   = int'($urandom_range(0, 9));
                dly = (r < 6) ? (r % 4) : ((r < 8) ? -1 : (4 + r - 8));
                rd_frame(ab, dly, int'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0));
            end else if (sel == 8) begin
                junk_byte();
            end else begin
                spur_data  = 8'($urandom);
                spur_valid = 1'b1;
                tick();
                spur_valid = 1'b0;
            end
            gap();
        end

        repeat (10) tick();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_events: %0d pending, required 0 (next kind=%0d cyc=%0d)",
                     exp_q.size(), exp_q[0].kind, exp_q[0].cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
